// File: rtl/braille_dot_driver.sv
`default_nettype none
// ============================================================================
// Module   : braille_dot_driver
// Purpose  : Turns one-cycle start strobes into timed hold/release drive on
//            braille solenoid pins, with a single-entry request buffer.
// Revision : 1.0 - initial release
// ============================================================================
module braille_dot_driver #(
    parameter int N_DOTS      = 6,
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int GAP_CYCLES  = 10_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_start,
    input  logic [N_DOTS-1:0] i_pattern,
    input  logic              i_cancel,
    output logic [N_DOTS-1:0] o_dots,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_overrun
);

    localparam int c_max_cycles = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int c_cnt_w      = $clog2(c_max_cycles + 1);
    localparam logic [c_cnt_w-1:0] c_hold_load = c_cnt_w'(HOLD_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_gap_load  = c_cnt_w'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t              r_state;
    logic [c_cnt_w-1:0]  r_cnt;
    logic                r_pend_valid;
    logic [N_DOTS-1:0]   r_pend_pat;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_pend_valid <= 1'b0;
            r_pend_pat   <= '0;
            o_dots       <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            o_done    <= 1'b0;
            o_overrun <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state <= S_HOLD;
                        r_cnt   <= c_hold_load;
                        o_dots  <= i_pattern;
                        o_busy  <= 1'b1;
                    end
                end

                S_HOLD: begin
                    if (i_cancel) begin
                        // Abort: release immediately, full gap, drop any queued work.
                        r_state      <= S_GAP;
                        r_cnt        <= c_gap_load;
                        o_dots       <= '0;
                        r_pend_valid <= 1'b0;
                    end else begin
                        if (i_start) begin
                            if (r_pend_valid) begin
                                o_overrun <= 1'b1;
                            end else begin
                                r_pend_valid <= 1'b1;
                                r_pend_pat   <= i_pattern;
                            end
                        end
                        if (r_cnt == '0) begin
                            r_state <= S_GAP;
                            r_cnt   <= c_gap_load;
                            o_dots  <= '0;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                end

                S_GAP: begin
                    if (i_cancel) begin
                        r_pend_valid <= 1'b0;
                    end
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                        if (i_start && !i_cancel) begin
                            if (r_pend_valid) begin
                                o_overrun <= 1'b1;
                            end else begin
                                r_pend_valid <= 1'b1;
                                r_pend_pat   <= i_pattern;
                            end
                        end
                    end else begin
                        // Last gap cycle: chain straight into the next request if one exists.
                        o_done <= 1'b1;
                        if (r_pend_valid && !i_cancel) begin
                            r_state      <= S_HOLD;
                            r_cnt        <= c_hold_load;
                            o_dots       <= r_pend_pat;
                            r_pend_valid <= 1'b0;
                            if (i_start) begin
                                o_overrun <= 1'b1;
                            end
                        end else if (i_start && !i_cancel) begin
                            r_state <= S_HOLD;
                            r_cnt   <= c_hold_load;
                            o_dots  <= i_pattern;
                        end else begin
                            r_state <= S_IDLE;
                            o_busy  <= 1'b0;
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    o_busy  <= 1'b0;
                    o_dots  <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_braille_dot_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_braille_dot_driver
// Purpose  : Scoreboard bench for braille_dot_driver (HOLD=4, GAP=2, 6 dots).
// Revision : 1.0 - initial release
// ============================================================================
module tb_braille_dot_driver;

    logic       clk;
    logic       reset;
    logic       i_start;
    logic [5:0] i_pattern;
    logic       i_cancel;
    logic [5:0] o_dots;
    logic       o_busy;
    logic       o_done;
    logic       o_overrun;

    int n_total;
    int n_bad;

    typedef struct {
        int         cyc;
        logic [8:0] vec;
    } exp_t;

    typedef struct {
        int         cyc;
        logic       start;
        logic [5:0] pat;
        logic       cancel;
    } stim_t;

    exp_t  exp_q[$];
    stim_t stim_q[$];

    braille_dot_driver #(
        .N_DOTS      (6),
        .HOLD_CYCLES (4),
        .GAP_CYCLES  (2)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .i_start   (i_start),
        .i_pattern (i_pattern),
        .i_cancel  (i_cancel),
        .o_dots    (o_dots),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_overrun (o_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] expv);
        n_total++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s got dots/busy/done/ovr=%b want=%b", tag, obs, expv);
        end
    endtask

    // Push the expected output vector for every cycle in [a,b].
    task automatic exp_win(input int a, input int b, input logic [5:0] d,
                           input logic busy, input logic done, input logic ovr);
        for (int c = a; c <= b; c++) begin
            exp_t e;
            e.cyc = c;
            e.vec = {d, busy, done, ovr};
            exp_q.push_back(e);
        end
    endtask

    task automatic stim(input int c, input logic s, input logic [5:0] p, input logic k);
        stim_t t;
        t.cyc = c; t.start = s; t.pat = p; t.cancel = k;
        stim_q.push_back(t);
    endtask

    task automatic do_reset();
        i_start = 1'b0; i_cancel = 1'b0; i_pattern = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {o_dots, o_busy, o_done, o_overrun}, 9'b0);
        reset = 1'b0;
    endtask

    task automatic run(input string name, input int last);
        for (int c = 0; c <= last; c++) begin
            @(posedge clk);
            #1;
            while (exp_q.size() > 0 && exp_q[0].cyc == c) begin
                exp_t e;
                e = exp_q.pop_front();
                chk($sformatf("%s_c%0d", name, c), {o_dots, o_busy, o_done, o_overrun}, e.vec);
            end
            i_start = 1'b0; i_cancel = 1'b0;
            if (stim_q.size() > 0 && stim_q[0].cyc == c) begin
                stim_t t;
                t = stim_q.pop_front();
                i_start = t.start; i_pattern = t.pat; i_cancel = t.cancel;
            end
        end
        i_start = 1'b0; i_cancel = 1'b0;
        if (exp_q.size() != 0 || stim_q.size() != 0) begin
            n_total++;
            n_bad++;
            $display("FAIL %s_leftover got exp=%0d stim=%0d want 0", name, exp_q.size(), stim_q.size());
            exp_q.delete();
            stim_q.delete();
        end
    endtask

    task automatic scn_single(input string name);
        do_reset();
        stim(10, 1'b1, 6'b101011, 1'b0);
        exp_win(0, 10, 6'b0, 0, 0, 0);
        exp_win(11, 14, 6'b101011, 1, 0, 0);
        exp_win(15, 16, 6'b0, 1, 0, 0);
        exp_win(17, 17, 6'b0, 0, 1, 0);
        exp_win(18, 20, 6'b0, 0, 0, 0);
        run(name, 20);
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        reset   = 1'b1;
        i_start = 1'b0; i_cancel = 1'b0; i_pattern = '0;

        scn_single("single");

        // Back-to-back: second request buffered, chained with no idle cycle.
        do_reset();
        stim(10, 1'b1, 6'b110000, 1'b0);
        stim(12, 1'b1, 6'b000111, 1'b0);
        exp_win(0, 10, 6'b0, 0, 0, 0);
        exp_win(11, 14, 6'b110000, 1, 0, 0);
        exp_win(15, 16, 6'b0, 1, 0, 0);
        exp_win(17, 17, 6'b000111, 1, 1, 0);
        exp_win(18, 20, 6'b000111, 1, 0, 0);
        exp_win(21, 22, 6'b0, 1, 0, 0);
        exp_win(23, 23, 6'b0, 0, 1, 0);
        exp_win(24, 26, 6'b0, 0, 0, 0);
        run("chain", 26);

        // Third start while buffer full is dropped; first buffered wins.
        do_reset();
        stim(10, 1'b1, 6'b000001, 1'b0);
        stim(12, 1'b1, 6'b000010, 1'b0);
        stim(13, 1'b1, 6'b000100, 1'b0);
        exp_win(0, 10, 6'b0, 0, 0, 0);
        exp_win(11, 13, 6'b000001, 1, 0, 0);
        exp_win(14, 14, 6'b000001, 1, 0, 1);
        exp_win(15, 16, 6'b0, 1, 0, 0);
        exp_win(17, 17, 6'b000010, 1, 1, 0);
        exp_win(18, 20, 6'b000010, 1, 0, 0);
        exp_win(21, 22, 6'b0, 1, 0, 0);
        exp_win(23, 23, 6'b0, 0, 1, 0);
        exp_win(24, 30, 6'b0, 0, 0, 0);
        run("overrun", 30);

        // Cancel in HOLD with a buffered request.
        do_reset();
        stim(10, 1'b1, 6'b111111, 1'b0);
        stim(11, 1'b1, 6'b010101, 1'b0);
        stim(12, 1'b0, 6'b0, 1'b1);
        exp_win(0, 10, 6'b0, 0, 0, 0);
        exp_win(11, 12, 6'b111111, 1, 0, 0);
        exp_win(13, 14, 6'b0, 1, 0, 0);
        exp_win(15, 15, 6'b0, 0, 1, 0);
        exp_win(16, 24, 6'b0, 0, 0, 0);
        run("cancel", 24);

        // Asynchronous reset between edges mid-HOLD.
        do_reset();
        stim(10, 1'b1, 6'b101011, 1'b0);
        exp_win(0, 10, 6'b0, 0, 0, 0);
        exp_win(11, 12, 6'b101011, 1, 0, 0);
        run("pre_areset", 12);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset", {o_dots, o_busy, o_done, o_overrun}, 9'b0);
        scn_single("after_areset");

        // Start coincident with last GAP cycle, buffer empty.
        do_reset();
        stim(10, 1'b1, 6'b100001, 1'b0);
        stim(16, 1'b1, 6'b011110, 1'b0);
        exp_win(0, 10, 6'b0, 0, 0, 0);
        exp_win(11, 14, 6'b100001, 1, 0, 0);
        exp_win(15, 16, 6'b0, 1, 0, 0);
        exp_win(17, 17, 6'b011110, 1, 1, 0);
        exp_win(18, 20, 6'b011110, 1, 0, 0);
        exp_win(21, 22, 6'b0, 1, 0, 0);
        exp_win(23, 23, 6'b0, 0, 1, 0);
        exp_win(24, 25, 6'b0, 0, 0, 0);
        run("gap_edge", 25);

        // All-zero pattern still runs full hold and gap.
        do_reset();
        stim(10, 1'b1, 6'b000000, 1'b0);
        exp_win(0, 10, 6'b0, 0, 0, 0);
        exp_win(11, 16, 6'b0, 1, 0, 0);
        exp_win(17, 17, 6'b0, 0, 1, 0);
        exp_win(18, 20, 6'b0, 0, 0, 0);
        run("zero_pat", 20);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
